fft_frame_ctrl: RTL and testbench
=================================

# fft_frame_ctrl

Frame sequencer in front of the FFT input stage. Accepts a point-size request and a stream of complex samples over a valid/ready handshake, latches the mode for the whole frame and counts exactly N samples into the FFT. It then holds off the next frame until the FFT reports its output complete. It is the only driver of the FFT's mode select, input enable and input data.

## Interface
- WIDTH, 16, sample width (real and imaginary each)
- clock  in  1  master clock
- reset  in  1  synchronous, active-high reset
- start  in  1  frame request pulse; honoured only in IDLE
- mode_i  in  3  point select at start: 3'b001 = 64-point, 3'b011 = 256-point
- s_valid  in  1  source sample valid
- s_ready  out  1  controller can take a sample
- s_re / s_im  in  WIDTH  source sample
- s_last  in  1  source end-of-frame marker (see Configuration)
- fft_en  out  1  FFT input data enable
- fft_re / fft_im  out  WIDTH  FFT input data
- fft_mode  out  3  FFT point select, stable for the whole frame
- fft_done  in  1  pulse from the FFT output stage: last output bin delivered
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse at end of a frame
- err_mode  out  1  one-cycle pulse when an unsupported mode_i is accepted
- sample_cnt  out  10  samples delivered in the current frame

## Operation
- States: IDLE, FEED, PAD, WAIT_DONE.
- **IDLE**
  - On start: latch mode_i into fft_mode, clear the counter and go to FEED.
  - mode_i values other than 001 and 011 are replaced by 011 (256-point), and err_mode pulses.
- **FEED**
  - s_ready = 1.
  - Each s_valid && s_ready handshake registers s_re/s_im onto fft_re/fft_im, sets fft_en for one cycle and increments sample_cnt.
  - cnt_max is 63 for 64-point and 255 for 256-point.
  - The handshake where sample_cnt == cnt_max goes to WAIT_DONE.
- **PAD** (macro only)
  - s_ready = 0.
  - Each cycle: fft_en = 1, data = 0, sample_cnt increments.
  - At cnt_max, go to WAIT_DONE.
- **WAIT_DONE**
  - s_ready = 0, fft_en = 0.
  - On fft_done: frame_done pulses, go to IDLE, sample_cnt clears.
- start outside IDLE is ignored. fft_done outside WAIT_DONE is ignored.
- start in the same cycle as fft_done in WAIT_DONE is ignored; the new start is taken from IDLE on a later cycle.
- When fft_en = 0, fft_re and fft_im are 0.
- sample_cnt is 10 bits; it never exceeds cnt_max, so it does not wrap.

## Timing
- **Reset:** state IDLE. s_ready, fft_en, busy, frame_done, err_mode = 0. fft_re, fft_im, sample_cnt = 0. fft_mode = 3'b011.
- **Start:** sampled at edge k. At k+1: busy = 1, s_ready = 1, fft_mode updated, err_mode pulses if applicable.
- **Latency:** handshake at edge k gives fft_en and data at k+1; exactly one register stage.
- **Throughput:** back-to-back samples are accepted one per cycle. s_valid gaps insert fft_en = 0 cycles without breaking the frame.
- **Frame end:** the final sample's fft_en and s_ready = 0 occur in the same cycle.
- **Done:** fft_done at edge k gives frame_done = 1 and busy = 0 at k+1.
- **Reset mid-frame:** immediate return to reset values. The partial frame is dropped and no frame_done is produced.

## Configuration
- Macro: FFT_FRAME_ZERO_PAD_EN.
- **Defined:** s_last on a FEED handshake with sample_cnt < cnt_max moves to PAD, which zero-fills up to cnt_max. s_last at cnt_max is a normal end.
- **Undefined:** s_last is ignored and the frame ends on count only. PAD is not built.

## Structure
- Shared package fft_pkg holds:
  - mode localparams MODE_64 = 3'b001 and MODE_256 = 3'b011
  - the default mode
  - the state encoding
  - CNT_W = 10
- One combinational sub-module, fft_mode_decode: mode_i in, cnt_max and mode_ok out. The FFT input stage will reuse it.

## Test plan
- **64-point frame:** start with mode_i = 001, then 64 continuous samples (re = index, im = −index).
  - fft_en high for 64 cycles, data matches one cycle later, fft_mode = 001 throughout.
  - s_ready drops after sample 63; fft_done then produces a frame_done pulse.
- **256-point with stalls:** mode 011, s_valid toggled randomly.
  - Exactly 256 fft_en pulses in order; sample_cnt = 255 before WAIT_DONE.
- **Bad mode:** mode_i = 101.
  - err_mode pulses once, fft_mode = 011, frame runs 256 samples.
- **Ignored events:** start and fft_done asserted during FEED.
  - No state change, no frame_done.
  - A second start after frame_done runs a fresh frame from sample_cnt = 0.
- **Reset mid-frame:** reset at sample 100 of 256.
  - Next cycle: all outputs at reset values, IDLE, no frame_done.
- **Short frame (macro on):** s_last on sample 40 of 64.
  - 24 zero-data fft_en cycles follow with s_ready = 0, then WAIT_DONE.
- **Short frame (macro off):** same stimulus continues in FEED until 64 real samples.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame controller and the FFT input stage:
// mode codes, default mode, counter width and FSM state encoding.
package fft_pkg;

    localparam int unsigned CNT_W  = 10;
    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_64      = 3'b001;
    localparam logic [MODE_W-1:0] MODE_256     = 3'b011;
    localparam logic [MODE_W-1:0] MODE_DEFAULT = MODE_256;

    localparam logic [CNT_W-1:0] CNT_MAX_64  = 10'd63;
    localparam logic [CNT_W-1:0] CNT_MAX_256 = 10'd255;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FEED      = 2'd1,
        ST_PAD       = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/fft_mode_decode.sv
// Point-select decoder: last sample index of a frame and whether the code is supported.
// Unsupported codes decode as the default 256-point mode.
module fft_mode_decode
    import fft_pkg::*;
(
    input  logic [MODE_W-1:0] mode_i,
    output logic [CNT_W-1:0]  cnt_max,
    output logic              mode_ok
);

    always_comb begin
        mode_ok = 1'b0;
        cnt_max = CNT_MAX_256;
        case (mode_i)
            MODE_64: begin
                mode_ok = 1'b1;
                cnt_max = CNT_MAX_64;
            end
            MODE_256: mode_ok = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer feeding the FFT input stage: latches the point size, counts N samples,
// then waits for fft_done. Zero-padding of short frames is built under FFT_FRAME_ZERO_PAD_EN.
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [MODE_W-1:0] mode_i,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WIDTH-1:0]  s_re,
    input  logic [WIDTH-1:0]  s_im,
    input  logic              s_last,
    output logic              fft_en,
    output logic [WIDTH-1:0]  fft_re,
    output logic [WIDTH-1:0]  fft_im,
    output logic [MODE_W-1:0] fft_mode,
    input  logic              fft_done,
    output logic              busy,
    output logic              frame_done,
    output logic              err_mode,
    output logic [CNT_W-1:0]  sample_cnt
);

    state_e state, state_nx;

    logic [CNT_W-1:0] cnt_max_q;
    logic [CNT_W-1:0] dec_cnt_max;
    logic             dec_mode_ok;
    logic             hs_c;
    logic             at_max_c;

    logic              s_ready_d, fft_en_d, busy_d, frame_done_d, err_mode_d;
    logic [WIDTH-1:0]  fft_re_d, fft_im_d;
    logic [MODE_W-1:0] fft_mode_d;
    logic [CNT_W-1:0]  sample_cnt_d, cnt_max_d;

    fft_mode_decode u_mode_decode (
        .mode_i  (mode_i),
        .cnt_max (dec_cnt_max),
        .mode_ok (dec_mode_ok)
    );

    assign hs_c     = s_valid && s_ready;
    assign at_max_c = (sample_cnt == cnt_max_q);

`ifndef FFT_FRAME_ZERO_PAD_EN
    logic unused_s_last;
    assign unused_s_last = s_last;
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_FEED;
            ST_FEED: begin
                if (hs_c) begin
                    if (at_max_c) state_nx = ST_WAIT_DONE;
`ifdef FFT_FRAME_ZERO_PAD_EN
                    else if (s_last) state_nx = ST_PAD;
`endif
                end
            end
`ifdef FFT_FRAME_ZERO_PAD_EN
            ST_PAD: if (at_max_c) state_nx = ST_WAIT_DONE;
`endif
            ST_WAIT_DONE: if (fft_done) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs; fft_mode and cnt_max hold for the whole frame.
    always_comb begin
        s_ready_d    = (state_nx == ST_FEED);
        busy_d       = (state_nx != ST_IDLE);
        fft_en_d     = 1'b0;
        fft_re_d     = '0;
        fft_im_d     = '0;
        frame_done_d = 1'b0;
        err_mode_d   = 1'b0;
        fft_mode_d   = fft_mode;
        cnt_max_d    = cnt_max_q;
        sample_cnt_d = sample_cnt;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    fft_mode_d   = dec_mode_ok ? mode_i : MODE_DEFAULT;
                    cnt_max_d    = dec_cnt_max;
                    err_mode_d   = !dec_mode_ok;
                    sample_cnt_d = '0;
                end
            end
            ST_FEED: begin
                if (hs_c) begin
                    fft_en_d = 1'b1;
                    fft_re_d = s_re;
                    fft_im_d = s_im;
                    if (!at_max_c) sample_cnt_d = sample_cnt + CNT_W'(1);
                end
            end
`ifdef FFT_FRAME_ZERO_PAD_EN
            ST_PAD: begin
                fft_en_d = 1'b1;
                if (!at_max_c) sample_cnt_d = sample_cnt + CNT_W'(1);
            end
`endif
            ST_WAIT_DONE: begin
                if (fft_done) begin
                    frame_done_d = 1'b1;
                    sample_cnt_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s_ready    <= 1'b0;
            busy       <= 1'b0;
            fft_en     <= 1'b0;
            fft_re     <= '0;
            fft_im     <= '0;
            frame_done <= 1'b0;
            err_mode   <= 1'b0;
            fft_mode   <= MODE_DEFAULT;
            cnt_max_q  <= CNT_MAX_256;
            sample_cnt <= '0;
        end else begin
            s_ready    <= s_ready_d;
            busy       <= busy_d;
            fft_en     <= fft_en_d;
            fft_re     <= fft_re_d;
            fft_im     <= fft_im_d;
            frame_done <= frame_done_d;
            err_mode   <= err_mode_d;
            fft_mode   <= fft_mode_d;
            cnt_max_q  <= cnt_max_d;
            sample_cnt <= sample_cnt_d;
        end
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl: expected FFT input words are queued as samples are
// driven and compared when fft_en is seen. Adapts the short-frame case to FFT_FRAME_ZERO_PAD_EN.
module tb_fft_frame_ctrl;

    localparam int unsigned WIDTH = 16;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic [9:0]  cnt;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [2:0]        mode_i = 3'b000;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [WIDTH-1:0]  s_re = '0;
    logic [WIDTH-1:0]  s_im = '0;
    logic              s_last = 1'b0;
    logic              fft_en;
    logic [WIDTH-1:0]  fft_re;
    logic [WIDTH-1:0]  fft_im;
    logic [2:0]        fft_mode;
    logic              fft_done = 1'b0;
    logic              busy;
    logic              frame_done;
    logic              err_mode;
    logic [9:0]        sample_cnt;

    exp_t       q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         en_cnt   = 0;
    int         done_cnt = 0;
    int         exp_done = 0;
    logic [2:0] exp_mode = 3'b011;

    fft_frame_ctrl #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .mode_i     (mode_i),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_re       (s_re),
        .s_im       (s_im),
        .s_last     (s_last),
        .fft_en     (fft_en),
        .fft_re     (fft_re),
        .fft_im     (fft_im),
        .fft_mode   (fft_mode),
        .fft_done   (fft_done),
        .busy       (busy),
        .frame_done (frame_done),
        .err_mode   (err_mode),
        .sample_cnt (sample_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Output monitor: pops one expected word per fft_en cycle, zero data otherwise.
    always @(negedge clock) begin
        if (!reset) begin
            if (frame_done) done_cnt++;
            if (fft_en) begin
                en_cnt++;
                if (q.size() == 0) begin
                    check("fft_en_unexpected", 32'(fft_en), 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("fft_re", 32'(fft_re), 32'(e.re));
                    check("fft_im", 32'(fft_im), 32'(e.im));
                    check("sample_cnt", 32'(sample_cnt), 32'(e.cnt));
                    check("fft_mode", 32'(fft_mode), 32'(exp_mode));
                end
            end else begin
                check("idle_data_zero", {fft_re, fft_im}, 32'd0);
            end
        end
    end

    task automatic check_reset_vals();
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_fft_en", 32'(fft_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_err_mode", 32'(err_mode), 32'd0);
        check("rst_data", {fft_re, fft_im}, 32'd0);
        check("rst_sample_cnt", 32'(sample_cnt), 32'd0);
        check("rst_fft_mode", 32'(fft_mode), 32'd3);
    endtask

    task automatic start_frame(input logic [2:0] mode, input logic [2:0] emode, input bit eerr);
        start  = 1'b1;
        mode_i = mode;
        @(posedge clock); #1;
        start  = 1'b0;
        mode_i = 3'b000;
        exp_mode = emode;
        check("start_busy", 32'(busy), 32'd1);
        check("start_s_ready", 32'(s_ready), 32'd1);
        check("start_fft_mode", 32'(fft_mode), 32'(emode));
        check("start_err_mode", 32'(err_mode), 32'(eerr));
        check("start_sample_cnt", 32'(sample_cnt), 32'd0);
        @(posedge clock); #1;
        check("err_mode_one_cycle", 32'(err_mode), 32'd0);
        en_cnt = 0;
    endtask

    // Drives n samples starting at frame position first; injects start+fft_done at index inj.
    task automatic send_samples(input int n, input int first, input int cmax, input bit stall,
                                input int last_at, input int inj);
        for (int i = 0; i < n; i++) begin
            int   pos;
            exp_t e;
            if (stall) begin
                while ($urandom_range(0, 2) == 0) begin
                    s_valid = 1'b0;
                    @(posedge clock); #1;
                end
            end
            check("s_ready_feed", 32'(s_ready), 32'd1);
            pos     = first + i;
            s_valid = 1'b1;
            s_re    = 16'(pos);
            s_im    = 16'(-pos);
            s_last  = (i == last_at);
            if (i == inj) begin
                start    = 1'b1;
                mode_i   = 3'b001;
                fft_done = 1'b1;
            end
            e.re  = 16'(pos);
            e.im  = 16'(-pos);
            e.cnt = 10'((pos + 1 > cmax) ? cmax : pos + 1);
            q.push_back(e);
            @(posedge clock); #1;
            s_valid  = 1'b0;
            s_last   = 1'b0;
            start    = 1'b0;
            mode_i   = 3'b000;
            fft_done = 1'b0;
        end
    endtask

    task automatic end_frame(input int cmax, input int n_en, input bit with_start);
        int k;
        check("end_s_ready_low", 32'(s_ready), 32'd0);
        check("end_fft_en_high", 32'(fft_en), 32'd1);
        k = 0;
        while (q.size() != 0 && k < 400) begin
            @(posedge clock); #1;
            k++;
        end
        check("drain_timeout", 32'(q.size()), 32'd0);
        check("wait_sample_cnt", 32'(sample_cnt), 32'(cmax));
        check("wait_busy", 32'(busy), 32'd1);
        check("wait_fft_en", 32'(fft_en), 32'd0);
        check("en_pulses", 32'(en_cnt), 32'(n_en));
        check("no_early_done", 32'(done_cnt), 32'(exp_done));
        fft_done = 1'b1;
        start    = with_start;
        mode_i   = 3'b001;
        @(posedge clock); #1;
        fft_done = 1'b0;
        start    = 1'b0;
        mode_i   = 3'b000;
        exp_done++;
        check("done_frame_done", 32'(frame_done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_s_ready", 32'(s_ready), 32'd0);
        check("done_sample_cnt", 32'(sample_cnt), 32'd0);
        @(posedge clock); #1;
        check("frame_done_pulse", 32'(frame_done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
        check("done_count", 32'(done_cnt), 32'(exp_done));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_reset_vals();
        reset = 1'b0;
        @(posedge clock); #1;

        // 64-point, continuous samples
        start_frame(3'b001, 3'b001, 1'b0);
        send_samples(64, 0, 63, 1'b0, -1, -1);
        end_frame(63, 64, 1'b0);

        // 256-point with random stalls; start and fft_done injected mid-frame
        start_frame(3'b011, 3'b011, 1'b0);
        send_samples(256, 0, 255, 1'b1, -1, 50);
        end_frame(255, 256, 1'b0);

        // Unsupported mode falls back to 256-point
        start_frame(3'b101, 3'b011, 1'b1);
        send_samples(256, 0, 255, 1'b0, -1, -1);
        end_frame(255, 256, 1'b0);

        // Reset after 100 of 256 samples
        start_frame(3'b011, 3'b011, 1'b0);
        send_samples(100, 0, 255, 1'b0, -1, -1);
        reset = 1'b1;
        @(posedge clock); #1;
        check_reset_vals();
        q.delete();
        reset = 1'b0;
        @(posedge clock); #1;
        check("post_reset_idle", 32'(busy), 32'd0);
        check("post_reset_no_done", 32'(done_cnt), 32'(exp_done));

        // Short frame: s_last on sample 40 of 64; start coincident with fft_done is dropped
        start_frame(3'b001, 3'b001, 1'b0);
        send_samples(40, 0, 63, 1'b0, 39, -1);
`ifdef FFT_FRAME_ZERO_PAD_EN
        for (int p = 40; p < 64; p++) begin
            exp_t e;
            e.re  = 16'd0;
            e.im  = 16'd0;
            e.cnt = 10'((p + 1 > 63) ? 63 : p + 1);
            q.push_back(e);
        end
        check("pad_s_ready_low", 32'(s_ready), 32'd0);
`else
        send_samples(24, 40, 63, 1'b0, -1, -1);
`endif
        end_frame(63, 64, 1'b1);

        // Fresh frame after the ignored start
        start_frame(3'b001, 3'b001, 1'b0);
        send_samples(64, 0, 63, 1'b1, -1, -1);
        end_frame(63, 64, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
